sys_axi_mem_responder: RTL and testbench

AXI4 subordinate (responder) model for the simulator target; the other end of the flat `sys_*` AXI bus that the hosted top drives as manager. It terminates read and write bursts into an internal word-addressed RAM of 32-bit words. Used as the system-memory stand-in on the hosted/simulator bench. One read and one write transaction outstanding at a time; the read and write channels operate independently.

---
 rtl/sys_axi_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_sys_axi_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_axi_mem_responder.sv
// rtl/sys_axi_mem_responder.sv - AXI4 subordinate terminating bursts into a word-addressed 32-bit RAM
//
// Optional feature macro: SYS_MEM_ERR_RESP_EN (range checking with SLVERR responses).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sys_aw*             write address channel (awready out; awvalid/id/len/size/burst/prot/addr in)
//   sys_w*              write data channel (wready out; wvalid/wdata/wlast/wstrb in)
//   sys_b*              write response channel (bready in; bvalid/bid/bresp out)
//   sys_ar*             read address channel (arready out; arvalid/id/len/size/burst/prot/addr in)
//   sys_r*              read data channel (rready in; rvalid/rid/rdata/rresp/rlast out)
module sys_axi_mem_responder #(
    parameter int          DEPTH_WORDS = 65536,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sys_awready,
    input  logic        sys_awvalid,
    input  logic [7:0]  sys_awid,
    input  logic [7:0]  sys_awlen,
    input  logic [2:0]  sys_awsize,
    input  logic [1:0]  sys_awburst,
    input  logic [2:0]  sys_awprot,
    input  logic [31:0] sys_awaddr,
    output logic        sys_wready,
    input  logic        sys_wvalid,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wlast,
    input  logic [3:0]  sys_wstrb,
    input  logic        sys_bready,
    output logic        sys_bvalid,
    output logic [7:0]  sys_bid,
    output logic [1:0]  sys_bresp,
    output logic        sys_arready,
    input  logic        sys_arvalid,
    input  logic [7:0]  sys_arid,
    input  logic [7:0]  sys_arlen,
    input  logic [2:0]  sys_arsize,
    input  logic [1:0]  sys_arburst,
    input  logic [2:0]  sys_arprot,
    input  logic [31:0] sys_araddr,
    input  logic        sys_rready,
    output logic        sys_rvalid,
    output logic [7:0]  sys_rid,
    output logic [31:0] sys_rdata,
    output logic [1:0]  sys_rresp,
    output logic        sys_rlast
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    w_state_t    w_state;
    logic [7:0]  w_id, w_len, w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [31:0] w_addr;
    logic        w_err;

    r_state_t    r_state;
    logic [7:0]  r_id, r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [31:0] r_addr;

    // FIXED holds the address; INCR, WRAP and reserved all step linearly.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    logic [31:0]   w_off, r_off;
    logic [AW-1:0] w_idx, r_idx;
    logic          w_ok, r_ok;

    assign w_off = w_addr - BASE_ADDR;
    assign r_off = r_addr - BASE_ADDR;
    assign w_idx = w_off[AW+1:2];
    assign r_idx = r_off[AW+1:2];

`ifdef SYS_MEM_ERR_RESP_EN
    assign w_ok = (w_addr >= BASE_ADDR) && ({2'b00, w_off[31:2]} < 32'(DEPTH_WORDS));
    assign r_ok = (r_addr >= BASE_ADDR) && ({2'b00, r_off[31:2]} < 32'(DEPTH_WORDS));
`else
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{sys_awprot, sys_arprot, sys_wlast, w_off, r_off};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_addr  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (sys_awvalid) begin
                    w_id    <= sys_awid;
                    w_addr  <= sys_awaddr;
                    w_len   <= sys_awlen;
                    w_size  <= sys_awsize;
                    w_burst <= sys_awburst;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (sys_wvalid) begin
                    w_addr <= next_addr(w_addr, w_size, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
`ifdef SYS_MEM_ERR_RESP_EN
                    // wlast only flags protocol errors; awlen alone ends the burst.
                    if (!w_ok || (sys_wlast != (w_cnt == w_len)))
                        w_err <= 1'b1;
`endif
                    if (w_cnt == w_len)
                        w_state <= W_RESP;
                end
                W_RESP: if (sys_bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // RAM is never reset; per-byte lane enables from wstrb.
    always_ff @(posedge clk) begin
        if (w_state == W_DATA && sys_wvalid && w_ok) begin
            for (int i = 0; i < 4; i++)
                if (sys_wstrb[i]) mem[w_idx][8*i +: 8] <= sys_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (sys_arvalid) begin
                    r_id    <= sys_arid;
                    r_addr  <= sys_araddr;
                    r_len   <= sys_arlen;
                    r_size  <= sys_arsize;
                    r_burst <= sys_arburst;
                    r_cnt   <= '0;
                    r_state <= R_DATA;
                end
                R_DATA: if (sys_rready) begin
                    r_addr <= next_addr(r_addr, r_size, r_burst);
                    r_cnt  <= r_cnt + 8'd1;
                    if (r_cnt == r_len) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign sys_awready = (w_state == W_IDLE);
    assign sys_wready  = (w_state == W_DATA);
    assign sys_bvalid  = (w_state == W_RESP);
    assign sys_bid     = w_id;
`ifdef SYS_MEM_ERR_RESP_EN
    assign sys_bresp   = w_err ? 2'b10 : 2'b00;
    assign sys_rresp   = (r_state == R_DATA && !r_ok) ? 2'b10 : 2'b00;
`else
    assign sys_bresp   = {1'b0, w_err & 1'b0};
    assign sys_rresp   = 2'b00;
`endif

    assign sys_arready = (r_state == R_IDLE);
    assign sys_rvalid  = (r_state == R_DATA);
    assign sys_rid     = r_id;
    assign sys_rlast   = (r_state == R_DATA) && (r_cnt == r_len);
    // Combinational read sees the pre-write word when a write lands in the same cycle.
    assign sys_rdata   = (r_state == R_DATA && r_ok) ? mem[r_idx] : 32'd0;
endmodule

// File: tb/tb_sys_axi_mem_responder.sv
// tb/tb_sys_axi_mem_responder.sv - directed scoreboard bench for sys_axi_mem_responder
module tb_sys_axi_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sys_awready, sys_awvalid = 1'b0;
    logic [7:0]  sys_awid = '0, sys_awlen = '0;
    logic [2:0]  sys_awsize = '0, sys_awprot = '0;
    logic [1:0]  sys_awburst = '0;
    logic [31:0] sys_awaddr = '0;
    logic        sys_wready, sys_wvalid = 1'b0, sys_wlast = 1'b0;
    logic [31:0] sys_wdata = '0;
    logic [3:0]  sys_wstrb = '0;
    logic        sys_bready = 1'b0, sys_bvalid;
    logic [7:0]  sys_bid;
    logic [1:0]  sys_bresp;
    logic        sys_arready, sys_arvalid = 1'b0;
    logic [7:0]  sys_arid = '0, sys_arlen = '0;
    logic [2:0]  sys_arsize = '0, sys_arprot = '0;
    logic [1:0]  sys_arburst = '0;
    logic [31:0] sys_araddr = '0;
    logic        sys_rready = 1'b0, sys_rvalid, sys_rlast;
    logic [7:0]  sys_rid;
    logic [31:0] sys_rdata;
    logic [1:0]  sys_rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [16];
    logic [31:0] wd [$];
    logic [9:0]  bq [$];
    logic [42:0] rq [$];

    always #5 clk = ~clk;

    sys_axi_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .sys_awready(sys_awready), .sys_awvalid(sys_awvalid), .sys_awid(sys_awid),
        .sys_awlen(sys_awlen), .sys_awsize(sys_awsize), .sys_awburst(sys_awburst),
        .sys_awprot(sys_awprot), .sys_awaddr(sys_awaddr),
        .sys_wready(sys_wready), .sys_wvalid(sys_wvalid), .sys_wdata(sys_wdata),
        .sys_wlast(sys_wlast), .sys_wstrb(sys_wstrb),
        .sys_bready(sys_bready), .sys_bvalid(sys_bvalid), .sys_bid(sys_bid), .sys_bresp(sys_bresp),
        .sys_arready(sys_arready), .sys_arvalid(sys_arvalid), .sys_arid(sys_arid),
        .sys_arlen(sys_arlen), .sys_arsize(sys_arsize), .sys_arburst(sys_arburst),
        .sys_arprot(sys_arprot), .sys_araddr(sys_araddr),
        .sys_rready(sys_rready), .sys_rvalid(sys_rvalid), .sys_rid(sys_rid),
        .sys_rdata(sys_rdata), .sys_rresp(sys_rresp), .sys_rlast(sys_rlast)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
`ifdef SYS_MEM_ERR_RESP_EN
        return a < 32'd64;
`else
        return (a == a);
`endif
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id, input logic [3:0] strb,
                            input int nsend);
        logic [31:0] a;
        logic        err;
        logic [9:0]  exp;
        a = addr;
        err = 1'b0;
        sys_awvalid = 1'b1; sys_awaddr = addr; sys_awlen = len; sys_awsize = size;
        sys_awburst = burst; sys_awid = id;
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (sys_awready) break; end
        check("aw_ready", 64'(sys_awready), 64'd1);
        @(posedge clk); #1;
        sys_awvalid = 1'b0;
        for (int b = 0; b <= int'(len) && b < nsend; b++) begin
            sys_wvalid = 1'b1; sys_wdata = wd[b]; sys_wstrb = strb; sys_wlast = (b == int'(len));
            for (int t = 0; t < 50; t++) begin @(negedge clk); if (sys_wready) break; end
            check("w_ready", 64'(sys_wready), 64'd1);
            if (in_range(a)) begin
                for (int i = 0; i < 4; i++)
                    if (strb[i]) model[a[5:2]][8*i +: 8] = wd[b][8*i +: 8];
            end else err = 1'b1;
            a = (burst == 2'b00) ? a : a + (32'd1 << size);
            @(posedge clk); #1;
        end
        sys_wvalid = 1'b0;
        sys_wlast = 1'b0;
        if (nsend > int'(len)) begin
            bq.push_back({id, err ? 2'b10 : 2'b00});
            sys_bready = 1'b1;
            for (int t = 0; t < 50; t++) begin @(negedge clk); if (sys_bvalid) break; end
            check("b_valid", 64'(sys_bvalid), 64'd1);
            exp = bq.pop_front();
            check("b_id_resp", 64'({sys_bid, sys_bresp}), 64'(exp));
            @(posedge clk); #1;
            sys_bready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id, input bit stall);
        logic [31:0] a;
        logic [42:0] cur, held, exp;
        bit          have_held;
        a = addr;
        have_held = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            rq.push_back({id, 1'(b == int'(len)), in_range(a) ? 2'b00 : 2'b10,
                          in_range(a) ? model[a[5:2]] : 32'd0});
            a = (burst == 2'b00) ? a : a + (32'd1 << size);
        end
        sys_arvalid = 1'b1; sys_araddr = addr; sys_arlen = len; sys_arsize = size;
        sys_arburst = burst; sys_arid = id;
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (sys_arready) break; end
        check("ar_ready", 64'(sys_arready), 64'd1);
        @(posedge clk); #1;
        sys_arvalid = 1'b0;
        sys_rready = 1'b1;
        @(negedge clk);
        check("r_first_latency", 64'(sys_rvalid), 64'd1);
        for (int c = 0; c < 64 && rq.size() > 0; c++) begin
            if (c > 0) @(negedge clk);
            cur = {sys_rid, sys_rlast, sys_rresp, sys_rdata};
            check("r_valid_b2b", 64'(sys_rvalid), 64'd1);
            if (have_held) check("r_hold", 64'(cur), 64'(held));
            have_held = 1'b0;
            if (sys_rvalid && sys_rready) begin
                exp = rq.pop_front();
                check("r_beat", 64'(cur), 64'(exp));
            end else if (sys_rvalid) begin
                held = cur;
                have_held = 1'b1;
            end
            @(posedge clk); #1;
            if (stall) sys_rready = ~sys_rready;
        end
        sys_rready = 1'b0;
        check("r_all_beats", 64'(rq.size()), 64'd0);
        rq.delete();
        @(negedge clk);
        check("r_idle_after", 64'({sys_rvalid, sys_rdata}), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'({sys_awready, sys_arready, sys_wready}), 64'b110);
        check("rst_valid", 64'({sys_bvalid, sys_rvalid, sys_rlast}), 64'd0);
        check("rst_ids", 64'({sys_bid, sys_rid, sys_bresp, sys_rresp}), 64'd0);
        check("rst_rdata", 64'(sys_rdata), 64'd0);
        @(posedge clk); #1;

        // 1: single write then single read
        wd = '{32'hDEADBEEF};
        do_write(32'h10, 8'd0, 3'd2, 2'b01, 8'h05, 4'hF, 1);
        do_read(32'h10, 8'd0, 3'd2, 2'b01, 8'h07, 1'b0);

        // 2: INCR burst, read back with rready toggling
        wd = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(32'h100, 8'd3, 3'd2, 2'b01, 8'h11, 4'hF, 4);
        do_read(32'h100, 8'd3, 3'd2, 2'b01, 8'h12, 1'b1);

        // 3: partial strobe
        wd = '{32'h11223344};
        do_write(32'h20, 8'd0, 3'd2, 2'b01, 8'h21, 4'hF, 1);
        wd = '{32'hAABBCCDD};
        do_write(32'h20, 8'd0, 3'd2, 2'b01, 8'h22, 4'b0101, 1);
        do_read(32'h20, 8'd0, 3'd2, 2'b01, 8'h23, 1'b0);

        // 4: FIXED burst lands every beat on the same word
        wd = '{32'd7, 32'd8, 32'd9};
        do_write(32'h40, 8'd2, 3'd2, 2'b00, 8'h31, 4'hF, 3);
        do_read(32'h40, 8'd0, 3'd2, 2'b01, 8'h32, 1'b0);
        do_read(32'h44, 8'd0, 3'd2, 2'b01, 8'h33, 1'b0);

        // 5: reset during W_DATA after one of four beats
        wd = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
        do_write(32'h30, 8'd3, 3'd2, 2'b01, 8'h41, 4'hF, 1);
        @(negedge clk);
        check("pre_rst_wready", 64'({sys_wready, sys_bvalid}), 64'b10);
        #2 rst = 1'b1;
        #6 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'({sys_awready, sys_wready, sys_arready}), 64'b101);
        for (int t = 0; t < 4; t++) begin
            check("post_rst_no_b", 64'(sys_bvalid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        do_read(32'h30, 8'd0, 3'd2, 2'b01, 8'h42, 1'b0);

        // 6: address beyond a 16-word RAM
        do_read(32'h40, 8'd0, 3'd2, 2'b01, 8'h51, 1'b0);
        wd = '{32'h00000055};
        do_write(32'h40, 8'd0, 3'd2, 2'b01, 8'h52, 4'hF, 1);
        do_read(32'h0, 8'd0, 3'd2, 2'b01, 8'h53, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
